// File: rtl/fetch_stage.sv
// Instruction-fetch front end: program counter, 1024x16 instruction memory
// with a load port, and the instruction register with field decode.
module fetch_stage #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 1 << ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  branch,
  input  logic                  stall,
  input  logic [ADDR_WIDTH-1:0] br_address,
  input  logic                  en_write,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [ADDR_WIDTH-1:0] instr_address,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic [5:0]            op_code,
  output logic                  reg_s,
  output logic                  acc_s,
  output logic [7:0]            val
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_pc;
  logic [DATA_WIDTH-1:0] r_ir;

  logic [ADDR_WIDTH-1:0] w_next_seq;
  logic [ADDR_WIDTH-1:0] w_pc_next;
  logic [DATA_WIDTH-1:0] w_rd_data;

  // Width of the adder result truncates naturally, so the last address wraps to 0.
  assign w_next_seq = r_pc + 1'b1;

  always_comb begin
    w_pc_next = w_next_seq;
    if (stall) begin
      w_pc_next = r_pc;
    end else if (branch) begin
      w_pc_next = br_address;
    end
  end

  assign w_rd_data = r_mem[r_pc];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc <= '0;
      r_ir <= '0;
    end else begin
      r_pc <= w_pc_next;
      r_ir <= w_rd_data;
    end
  end

  // Memory is deliberately left out of reset so a loaded program survives it.
  always_ff @(posedge clk) begin
    if (en_write && !reset) begin
      r_mem[r_pc] <= data_in;
    end
  end

  assign instr_address = r_pc;
  assign data_out      = w_rd_data;
  assign op_code       = r_ir[15:10];
  assign reg_s         = r_ir[9];
  assign acc_s         = r_ir[8];
  assign val           = r_ir[7:0];

endmodule

// File: tb/tb_fetch_stage.sv
// Randomised scoreboard bench for fetch_stage against a simple array-based
// model of the program counter, instruction memory and instruction register.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        branch;
  logic        stall;
  logic [9:0]  br_address;
  logic        en_write;
  logic [15:0] data_in;
  logic [9:0]  instr_address;
  logic [15:0] data_out;
  logic [5:0]  op_code;
  logic        reg_s;
  logic        acc_s;
  logic [7:0]  val;

  fetch_stage dut (
    .clk           (clk),
    .reset         (reset),
    .branch        (branch),
    .stall         (stall),
    .br_address    (br_address),
    .en_write      (en_write),
    .data_in       (data_in),
    .instr_address (instr_address),
    .data_out      (data_out),
    .op_code       (op_code),
    .reg_s         (reg_s),
    .acc_s         (acc_s),
    .val           (val)
  );

  always #5 clk = ~clk;

  typedef struct {
    int unsigned pc;
    int unsigned ir;
    bit          ir_k;
    int unsigned dout;
    bit          dout_k;
  } exp_t;

  exp_t        sb_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;

  // Reference model state: plain integers, one array slot per memory word.
  int unsigned m_mem   [1024];
  bit          m_known [1024];
  int unsigned m_pc;
  int unsigned m_ir;
  bit          m_ir_k;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: the DUT presents a settled state every cycle; compare on the falling edge.
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      chk("pc", {22'd0, instr_address}, e.pc);
      if (e.ir_k) begin
        chk("op_code", {26'd0, op_code}, (e.ir >> 10) & 32'h3F);
        chk("reg_s",   {31'd0, reg_s},   (e.ir >> 9) & 32'h1);
        chk("acc_s",   {31'd0, acc_s},   (e.ir >> 8) & 32'h1);
        chk("val",     {24'd0, val},     e.ir & 32'hFF);
      end
      if (e.dout_k) chk("data_out", {16'd0, data_out}, e.dout);
    end
  end

  task automatic step(input bit s, input bit b, input int unsigned ba,
                      input bit we, input int unsigned din);
    exp_t e;
    stall      = s;
    branch     = b;
    br_address = ba[9:0];
    en_write   = we;
    data_in    = din[15:0];
    m_ir   = m_mem[m_pc];
    m_ir_k = m_known[m_pc];
    if (we) begin
      m_mem[m_pc]   = din & 32'hFFFF;
      m_known[m_pc] = 1'b1;
    end
    if (!s) m_pc = b ? (ba % 1024) : ((m_pc + 1) % 1024);
    e.pc     = m_pc;
    e.ir     = m_ir;
    e.ir_k   = m_ir_k;
    e.dout   = m_mem[m_pc];
    e.dout_k = m_known[m_pc];
    @(posedge clk);
    #1;
    sb_q.push_back(e);
  endtask

  // Mid-cycle asynchronous reset pulse, checked before any clock edge.
  task automatic pulse_reset(input int unsigned exp_dout);
    @(negedge clk);
    #1;
    en_write = 1'b0;
    stall    = 1'b0;
    branch   = 1'b0;
    reset    = 1'b1;
    m_pc = 0; m_ir = 0; m_ir_k = 1'b1;
    #1;
    chk("rst_pc",      {22'd0, instr_address}, 0);
    chk("rst_op_code", {26'd0, op_code}, 0);
    chk("rst_reg_s",   {31'd0, reg_s}, 0);
    chk("rst_acc_s",   {31'd0, acc_s}, 0);
    chk("rst_val",     {24'd0, val}, 0);
    chk("rst_data_out", {16'd0, data_out}, exp_dout);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned w;
    reset = 1'b1; branch = 1'b0; stall = 1'b0; br_address = '0;
    en_write = 1'b0; data_in = '0;
    for (int i = 0; i < 1024; i++) begin m_mem[i] = 0; m_known[i] = 1'b0; end
    m_pc = 0; m_ir = 0; m_ir_k = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Load the whole memory; PC free-runs 0..1023 and wraps back to 0.
    for (int i = 0; i < 1024; i++) begin
      case (i)
        0: w = 32'h040D;
        1: w = 32'h280C;
        2: w = 32'h2C14;
        3: w = 32'h080D;
        5: w = 32'h1111;
        default: w = $urandom_range(0, 65535);
      endcase
      step(0, 0, 0, 1, w);
    end
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);

    pulse_reset(32'h040D);
    step(0, 0, 0, 0, 0);          // IR = 0x040D
    step(0, 0, 0, 0, 0);          // IR = 0x280C

    step(0, 1, 500, 0, 0);        // branch to 500
    step(0, 0, 0, 0, 0);          // 501

    step(0, 1, 3, 0, 0);          // PC = 3
    step(1, 1, 7, 0, 0);          // stall beats branch, IR re-latches mem[3]
    step(1, 0, 0, 0, 0);

    step(0, 1, 1023, 0, 0);       // PC = 1023
    step(0, 0, 0, 0, 0);          // wraps to 0
    step(0, 0, 0, 0, 0);

    step(0, 1, 5, 0, 0);          // PC = 5 holding 0x1111
    step(1, 0, 0, 1, 32'h2222);   // IR takes old word, data_out shows new
    step(0, 0, 0, 0, 0);          // IR = 0x2222

    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
           $urandom_range(0, 1023), ($urandom_range(0, 2) == 0),
           $urandom_range(0, 65535));
      if (i == 200) pulse_reset(m_mem[0]);
    end
    stall = 1'b0; branch = 1'b0; en_write = 1'b0;

    for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(negedge clk);
    #1;
    if (sb_q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch front end of the 16-bit processor. Contains the program counter with its +1 incrementer, a 1024x16 instruction memory with a write port for program loading, and the instruction register with field decode.
- Feeds op_code, register/accumulator selects and the 8-bit immediate to the decode/execute stages.
- The memory is loaded through the write port while the PC steps through addresses; it is then read back after a reset.

Parameters:
- ADDR_WIDTH, 10, PC and memory address width.
- DATA_WIDTH, 16, instruction width; field split below assumes 16.
- DEPTH, 1024, memory words (2**ADDR_WIDTH).

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high; clears PC and IR.
- branch  in  1  load PC from br_address at next edge.
- stall  in  1  hold PC at next edge.
- br_address  in  10  branch target.
- en_write  in  1  write data_in into memory at address PC on rising edge.
- data_in  in  16  program word to write.
- instr_address  out  10  current PC value; it is also the memory address.
- data_out  out  16  memory word at instr_address (combinational read).
- op_code  out  6  IR[15:10].
- reg_s  out  1  IR[9].
- acc_s  out  1  IR[8].
- val  out  8  IR[7:0].

Behaviour:
- Reset (asynchronous, active-high): PC = 0 and IR = 0 immediately, so op_code = 0, reg_s = 0, acc_s = 0 and val = 0.
- Memory contents are NOT cleared by reset; the program survives a reset.
- While reset is high, memory writes are suppressed and PC/IR hold 0.
- PC incrementer: next_seq = PC + 1, modulo 1024, so 1023 wraps to 0.
- PC update at each rising edge when reset is low:
  - stall = 1: PC holds. Stall has priority over branch.
  - else branch = 1: PC = br_address.
  - else: PC = next_seq.
- Memory read: data_out = mem[instr_address], combinational with zero latency.
- Memory write: at the rising edge, if en_write = 1 and reset = 0, mem[PC] = data_in, using the PC value before the edge. After the edge data_out reflects the new value if the address is unchanged.
- With en_write = 1 and no stall or branch, consecutive edges write consecutive addresses 0, 1, 2, ...
- Stall together with en_write rewrites the same address.
- IR: at each rising edge (reset low), IR = data_out sampled before the edge. On a simultaneous write to the same address, IR captures the OLD word.
  - Fetch latency: the word at PC appears on the decode outputs one edge after PC presents its address.
- IR updates regardless of stall. The IR has no enable; stall freezes only the PC, so a stalled IR re-latches the same word.
- Decode outputs are pure slices of IR (registered), with no extra logic.
- Uninitialised memory reads as X in simulation. No reset-based initialisation is required.

Test Plan:
- Reset: assert reset asynchronously mid-cycle -> instr_address = 0 and op_code/reg_s/acc_s/val = 0 immediately, with no clock edge needed.
- Program load then readback: with en_write = 1, write 0x040D, 0x280C, 0x2C14, 0x080D at PC 0..3. Then pulse reset and set en_write = 0 -> data_out = 0x040D at PC 0. After the next edge op_code = 6'b000001, reg_s = 0, acc_s = 0, val = 0x0D. Next IR = 0x280C gives op_code = 6'b001010, val = 0x0C.
- Branch: branch = 1, br_address = 10'd500 -> instr_address = 500 after one edge. Then branch = 0 -> 501.
- Stall priority: stall = 1 and branch = 1 with br_address = 7 and PC = 3 -> PC remains 3. IR re-latches mem[3].
- Wrap: branch to 1023, then free-run -> PC = 0 after the following edge.
- Write/read same edge: en_write = 1 and stall = 1 at PC 5 holding 0x1111, data_in = 0x2222 -> IR captures 0x1111 at that edge, data_out = 0x2222 after it, and IR = 0x2222 after the next edge.
